// File: rtl/spi_rx_ram_writer_pkg.sv
// spi_ram_pkg: shared types and defaults for the SPI-to-RAM writer.
//   state_t  - writer FSM states
//   *_DEF    - default RAM word-address width, depth and byte-length width
//   lane_be  - one-hot byte enable for a given byte lane
package spi_ram_pkg;

   localparam int ADDR_W_DEF = 15;
   localparam int DEPTH_DEF  = 20480;
   localparam int LEN_W_DEF  = 17;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic logic [3:0] lane_be(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/spi_rx_ram_writer_if.sv
// spi_rx_ram_writer_if: byte stream in, Avalon-MM write master out.
//   s_data/s_valid/s_ready                  - incoming SPI byte stream
//   m_chipselect/m_write/m_address/
//   m_writedata/m_byteenable/m_waitrequest  - RAM Avalon-MM port
// modport master: the writer's view; modport slave: the stream source / RAM side.
interface spi_rx_ram_writer_if #(
   parameter int ADDR_W = spi_ram_pkg::ADDR_W_DEF
);

   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              m_chipselect;
   logic              m_write;
   logic [ADDR_W-1:0] m_address;
   logic [31:0]       m_writedata;
   logic [3:0]        m_byteenable;
   logic              m_waitrequest;

   modport master (
      input  s_data, s_valid, m_waitrequest,
      output s_ready, m_chipselect, m_write, m_address, m_writedata, m_byteenable
   );

   modport slave (
      output s_data, s_valid, m_waitrequest,
      input  s_ready, m_chipselect, m_write, m_address, m_writedata, m_byteenable
   );

endinterface

// File: rtl/spi_rx_ram_writer_word_packer.sv
// spi_ram_word_packer: packs bytes little-endian into a 32-bit word.
//   clear_i     - empty the word (data, enables and lane index to 0)
//   load_i      - store data_i into the current lane and advance the lane
//   word_o      - packed word, unfilled lanes are 0
//   be_o        - byte enables of the filled lanes
//   last_lane_o - the next load fills lane 3 and completes the word
module spi_ram_word_packer
   import spi_ram_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear_i,
   input  logic        load_i,
   input  logic [7:0]  data_i,
   output logic [31:0] word_o,
   output logic [3:0]  be_o,
   output logic        last_lane_o
);

   logic [31:0] word_q, word_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  lane_q, lane_d;

   always_comb begin
      word_d = word_q;
      be_d   = be_q;
      lane_d = lane_q;
      if (clear_i) begin
         word_d = '0;
         be_d   = '0;
         lane_d = '0;
      end else if (load_i) begin
         word_d[{lane_q, 3'b000} +: 8] = data_i;
         be_d   = be_q | lane_be(lane_q);
         lane_d = lane_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q <= '0;
         be_q   <= '0;
         lane_q <= '0;
      end else begin
         word_q <= word_d;
         be_q   <= be_d;
         lane_q <= lane_d;
      end
   end

   assign word_o      = word_q;
   assign be_o        = be_q;
   assign last_lane_o = (lane_q == 2'd3);

endmodule

// File: rtl/spi_rx_ram_writer.sv
// spi_rx_ram_writer: lands an SPI byte stream in RAM as 32-bit words.
//   clk, reset_n          - clock, async active-low reset
//   start                 - one-cycle request, latches base_addr/byte_len
//   base_addr, byte_len   - first RAM word address, number of bytes
//   busy, done, err_range - transfer status (done/err_range are 1-cycle pulses)
//   bus (master)          - byte stream in, Avalon-MM write master out
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for start; range/zero-length checks made here
// ST_COLLECT | s_ready=1, packing bytes until word full or bytes exhausted
// ST_WRITE   | Avalon write of the packed word, held while waitrequest
// ST_DONE    | one-cycle done (and err_range on a rejected request)
module spi_rx_ram_writer
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  byte_len,
   output logic              busy,
   output logic              done,
   output logic              err_range,
   spi_rx_ram_writer_if.master bus
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic              err_q, err_d;

   logic              pk_clear, pk_load, pk_last_lane;
   logic [31:0]       pk_word;
   logic [3:0]        pk_be;

   // Request end address, one bit wider than the RAM address so the sum of
   // base and rounded-up word count cannot overflow.
   logic [LEN_W:0]    len_round;
   logic [ADDR_W:0]   req_words;
   logic [ADDR_W:0]   req_end;
   logic              range_bad;

   assign len_round = {1'b0, byte_len} + (LEN_W+1)'(3);
   assign req_words = (ADDR_W+1)'(len_round[LEN_W:2]);
   assign req_end   = {1'b0, base_addr} + req_words;
   assign range_bad = (req_end > (ADDR_W+1)'(DEPTH));

   spi_ram_word_packer u_packer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear_i     (pk_clear),
      .load_i      (pk_load),
      .data_i      (bus.s_data),
      .word_o      (pk_word),
      .be_o        (pk_be),
      .last_lane_o (pk_last_lane)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      err_d    = err_q;
      pk_clear = 1'b0;
      pk_load  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (byte_len == '0) begin
                  err_d   = 1'b0;
                  state_d = ST_DONE;
               end else if (range_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  err_d    = 1'b0;
                  addr_d   = base_addr;
                  remain_d = byte_len;
                  pk_clear = 1'b1;
                  state_d  = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (bus.s_valid) begin
               pk_load  = 1'b1;
               remain_d = remain_q - LEN_W'(1);
               if (pk_last_lane || (remain_q == LEN_W'(1))) begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (!bus.m_waitrequest) begin
               addr_d   = addr_q + ADDR_W'(1);
               pk_clear = 1'b1;
               state_d  = (remain_q == '0) ? ST_DONE : ST_COLLECT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         err_q    <= err_d;
      end
   end

   assign busy             = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
   assign done             = (state_q == ST_DONE);
   assign err_range        = (state_q == ST_DONE) && err_q;
   assign bus.s_ready      = (state_q == ST_COLLECT);
   assign bus.m_chipselect = (state_q == ST_WRITE);
   assign bus.m_write      = (state_q == ST_WRITE);
   assign bus.m_address    = addr_q;
   assign bus.m_writedata  = pk_word;
   assign bus.m_byteenable = pk_be;

endmodule

// File: tb/tb_spi_rx_ram_writer.sv
module tb_spi_rx_ram_writer;
   import spi_ram_pkg::*;

   localparam int ADDR_W = 15;
   localparam int DEPTH  = 20480;
   localparam int LEN_W  = 17;

   logic              clk       = 1'b0;
   logic              reset_n   = 1'b0;
   logic              start     = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  byte_len  = '0;
   logic              busy, done, err_range;

   spi_rx_ram_writer_if #(.ADDR_W(ADDR_W)) bus ();

   spi_rx_ram_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .byte_len  (byte_len),
      .busy      (busy),
      .done      (done),
      .err_range (err_range),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        be;
   } wr_t;

   typedef struct {
      logic [ADDR_W-1:0] base;
      int                len;
      logic [7:0]        first;
      int                exp_writes;
      int                exp_err;
      int                exp_done_cyc;
      logic [31:0]       exp_last_data;
      logic [3:0]        exp_last_be;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   wr_t  got_q[$];
   logic [7:0] cur_bytes [0:63];
   int   done_cnt, err_cnt, busy_cnt, stall_chk;
   bit   prev_stall = 1'b0;
   wr_t  prev_wr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Bus monitor: captures accepted writes, pulses and stall stability.
   always @(negedge clk) begin
      wr_t w;
      if (bus.m_chipselect && bus.m_write && !bus.m_waitrequest) begin
         w.addr = bus.m_address;
         w.data = bus.m_writedata;
         w.be   = bus.m_byteenable;
         got_q.push_back(w);
      end
      if (done) done_cnt++;
      if (err_range) begin
         err_cnt++;
         chk("err_with_done", 64'(done), 64'd1);
      end
      if (busy) busy_cnt++;
      if (bus.m_write) chk("sready_low_in_write", 64'(bus.s_ready), 64'd0);
      if (prev_stall) begin
         stall_chk++;
         chk("stall_hold",
             64'({bus.m_chipselect, bus.m_write, bus.m_address, bus.m_writedata, bus.m_byteenable}),
             64'({2'b11, prev_wr.addr, prev_wr.data, prev_wr.be}));
      end
      prev_stall   = reset_n && bus.m_write && bus.m_waitrequest;
      prev_wr.addr = bus.m_address;
      prev_wr.data = bus.m_writedata;
      prev_wr.be   = bus.m_byteenable;
   end

   // One transfer: pulse start, feed cur_bytes with optional valid gaps and
   // random waitrequest. hold3 forces waitrequest high for the first three
   // cycles of the first write; poke re-pulses start at that loop cycle.
   task automatic run_xfer(input logic [ADDR_W-1:0] b, input int len, input int stall_pct,
                           input int gap_pct, input bit hold3, input int poke,
                           output int done_cyc);
      int idx, cyc, stall_left;
      bit got, hs;
      got_q.delete();
      done_cnt = 0; err_cnt = 0; busy_cnt = 0; stall_chk = 0;
      base_addr = b;
      byte_len  = LEN_W'(len);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      idx = 0; cyc = 0; got = 1'b0; done_cyc = -1;
      stall_left = hold3 ? 3 : 0;
      while (!got && cyc < 2000) begin
         start = (cyc == poke);
         if (cyc == poke) begin
            base_addr = '0;
            byte_len  = LEN_W'(4);
         end
         bus.s_valid = (idx < len) && (idx < 64) && ($urandom_range(99) >= gap_pct);
         bus.s_data  = (idx < 64) ? cur_bytes[idx] : 8'h00;
         if (stall_left > 0 && bus.m_write) begin
            bus.m_waitrequest = 1'b1;
            stall_left--;
         end else begin
            bus.m_waitrequest = ($urandom_range(99) < stall_pct);
         end
         @(negedge clk);
         hs = bus.s_valid && bus.s_ready;
         if (done) begin
            got = 1'b1;
            done_cyc = cyc;
         end
         @(posedge clk); #1;
         if (hs) idx++;
         cyc++;
      end
      start = 1'b0; bus.s_valid = 1'b0; bus.m_waitrequest = 1'b0;
      if (!got) chk("done_timeout", 64'd0, 64'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Reference: split the byte list into words of four, little-endian.
   task automatic check_model(input string tag, input logic [ADDR_W-1:0] b, input int len);
      int nw;
      bit bad;
      logic [31:0] d;
      logic [3:0]  e;
      nw  = (len + 3) / 4;
      bad = (len != 0) && (int'(b) + nw > DEPTH);
      if (bad || len == 0) nw = 0;
      chk({tag, ".done_count"}, 64'(done_cnt), 64'd1);
      chk({tag, ".err_count"}, 64'(err_cnt), 64'(bad));
      chk({tag, ".write_count"}, 64'(got_q.size()), 64'(nw));
      for (int w = 0; w < nw && w < got_q.size(); w++) begin
         d = '0;
         e = '0;
         for (int j = 0; j < 4; j++) begin
            if (4 * w + j < len) begin
               d[8*j +: 8] = cur_bytes[4*w+j];
               e[j] = 1'b1;
            end
         end
         chk($sformatf("%s.addr%0d", tag, w), 64'(got_q[w].addr), 64'(int'(b) + w));
         chk($sformatf("%s.data%0d", tag, w), 64'(got_q[w].data), 64'(d));
         chk($sformatf("%s.be%0d", tag, w), 64'(got_q[w].be), 64'(e));
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      chk({tag, ".done"}, 64'(done), 64'd0);
      chk({tag, ".err_range"}, 64'(err_range), 64'd0);
      chk({tag, ".s_ready"}, 64'(bus.s_ready), 64'd0);
      chk({tag, ".m_chipselect"}, 64'(bus.m_chipselect), 64'd0);
      chk({tag, ".m_write"}, 64'(bus.m_write), 64'd0);
      chk({tag, ".m_address"}, 64'(bus.m_address), 64'd0);
      chk({tag, ".m_writedata"}, 64'(bus.m_writedata), 64'd0);
      chk({tag, ".m_byteenable"}, 64'(bus.m_byteenable), 64'd0);
   endtask

   vec_t vecs [9];

   initial begin
      int dc;
      logic [ADDR_W-1:0] rb;
      int rl;

      vecs[0] = '{15'h0010, 8,     8'h01, 2, 0, 10, 32'h08070605, 4'hF};
      vecs[1] = '{15'h0000, 5,     8'h11, 2, 0, 7,  32'h00000015, 4'h1};
      vecs[2] = '{15'd20479, 5,    8'h00, 0, 1, 0,  32'h0,        4'h0};
      vecs[3] = '{15'd20478, 8,    8'h21, 2, 0, 10, 32'h28272625, 4'hF};
      vecs[4] = '{15'h0005, 0,     8'h00, 0, 0, 0,  32'h0,        4'h0};
      vecs[5] = '{15'd20480, 1,    8'h00, 0, 1, 0,  32'h0,        4'h0};
      vecs[6] = '{15'd20400, 3,    8'h31, 1, 0, 4,  32'h00333231, 4'h7};
      vecs[7] = '{15'h0000, 81921, 8'h00, 0, 1, 0,  32'h0,        4'h0};
      vecs[8] = '{15'h0000, 6,     8'h41, 2, 0, 8,  32'h00004645, 4'h3};

      bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.m_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed table, no stalls or gaps so latencies are exact.
      foreach (vecs[i]) begin
         for (int j = 0; j < 64; j++) cur_bytes[j] = 8'(int'(vecs[i].first) + j);
         run_xfer(vecs[i].base, vecs[i].len, 0, 0, 1'b0, -1, dc);
         chk($sformatf("vec%0d.writes", i), 64'(got_q.size()), 64'(vecs[i].exp_writes));
         chk($sformatf("vec%0d.err", i), 64'(err_cnt), 64'(vecs[i].exp_err));
         chk($sformatf("vec%0d.done_lat", i), 64'(dc), 64'(vecs[i].exp_done_cyc));
         chk($sformatf("vec%0d.busy_len", i), 64'(busy_cnt), 64'(vecs[i].exp_done_cyc));
         if (vecs[i].exp_writes > 0 && got_q.size() > 0) begin
            chk($sformatf("vec%0d.last_data", i), 64'(got_q[got_q.size()-1].data), 64'(vecs[i].exp_last_data));
            chk($sformatf("vec%0d.last_be", i), 64'(got_q[got_q.size()-1].be), 64'(vecs[i].exp_last_be));
         end
         check_model($sformatf("vec%0d", i), vecs[i].base, vecs[i].len);
      end

      // Three-cycle waitrequest on a single-word write.
      for (int j = 0; j < 64; j++) cur_bytes[j] = 8'(8'h51 + j);
      run_xfer(15'h0100, 4, 0, 0, 1'b1, -1, dc);
      chk("stall.cmp_count", 64'(stall_chk), 64'd3);
      chk("stall.busy_len", 64'(busy_cnt), 64'd8);
      if (got_q.size() > 0) chk("stall.data", 64'(got_q[0].data), 64'h54535251);
      check_model("stall", 15'h0100, 4);

      // Second start while busy must be ignored.
      for (int j = 0; j < 64; j++) cur_bytes[j] = 8'(8'h71 + j);
      run_xfer(15'h0040, 8, 0, 0, 1'b0, 3, dc);
      chk("restart.busy_len", 64'(busy_cnt), 64'd10);
      check_model("restart", 15'h0040, 8);

      // Reset after two bytes of a word.
      got_q.delete();
      done_cnt = 0;
      base_addr = 15'h0200; byte_len = LEN_W'(8); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bus.s_valid = 1'b1; bus.s_data = 8'h61;
      @(posedge clk); #1;
      bus.s_data = 8'h62;
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      chk("pre_reset.m_address", 64'(bus.m_address), 64'h200);
      chk("pre_reset.m_writedata", 64'(bus.m_writedata), 64'h6261);
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset.writes", 64'(got_q.size()), 64'd0);
      chk("post_reset.done", 64'(done_cnt), 64'd0);
      for (int j = 0; j < 64; j++) cur_bytes[j] = 8'(8'hA0 + j);
      run_xfer(15'h0300, 4, 0, 0, 1'b0, -1, dc);
      if (got_q.size() > 0) chk("post_reset.data", 64'(got_q[0].data), 64'hA3A2A1A0);
      check_model("post_reset", 15'h0300, 4);

      // Randomized transfers with stalls and stream gaps.
      for (int t = 0; t < 25; t++) begin
         rl = $urandom_range(0, 40);
         rb = ($urandom_range(1) == 1) ? ADDR_W'($urandom_range(0, 200))
                                       : ADDR_W'($urandom_range(20465, 20480));
         for (int j = 0; j < 64; j++) cur_bytes[j] = 8'($urandom);
         run_xfer(rb, rl, 25, 30, 1'b0, -1, dc);
         check_model($sformatf("rand%0d", t), rb, rl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
